// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch.
package bcd_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned DIGIT_MAX_UNITS = 9;
    localparam int unsigned DIGIT_MAX_TENS  = 5;

endpackage

// File: rtl/bcd_digit.sv
// Single mod-(MAX+1) BCD digit; carry is combinational so a chain of digits
// all advance on the same edge.
module bcd_digit
    import bcd_pkg::*;
#(
    parameter int unsigned MAX = DIGIT_MAX_UNITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MaxVal = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MaxVal) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MaxVal);

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch: start/stop FSM, one-second prescaler and a four-digit BCD
// carry chain.
module bcd_stopwatch
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               running,
    output logic               rollover
);

    localparam int unsigned       PrescW   = $clog2(TICK_DIV);
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

    state_e            state_q, state_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic              rollover_q, rollover_d;
    logic              tick;
    logic [3:0]        inc;
    logic [3:0]        carry;

    assign tick = (state_q == RUNNING) && (presc_q == PrescMax);

    // Stop wins over a coincident start; clear never affects the state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOPPED: if (start && !stop) state_d = RUNNING;
            RUNNING: if (stop)           state_d = STOPPED;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // The top digit only carries on the 59:59 wrap; clear suppresses it.
    assign rollover_d = carry[3] && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STOPPED;
            presc_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            rollover_q <= rollover_d;
        end
    end

    assign inc = {carry[2:0], tick};

    bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_sec_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (inc[0]),
        .digit (sec_ones),
        .carry (carry[0])
    );

    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (inc[1]),
        .digit (sec_tens),
        .carry (carry[1])
    );

    bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (inc[2]),
        .digit (min_ones),
        .carry (carry[2])
    );

    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (inc[3]),
        .digit (min_tens),
        .carry (carry[3])
    );

    assign running  = (state_q == RUNNING);
    assign rollover = rollover_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch with TICK_DIV=4: per-cycle scoreboard
// against a seconds-count model, a vector table and hand-written corner cases.
module tb_bcd_stopwatch;

    localparam int unsigned TickDiv = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;
    logic [15:0] dut_bcd;

    assign dut_bcd = {min_tens, min_ones, sec_tens, sec_ones};

    bcd_stopwatch #(.TICK_DIV(TickDiv)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .running  (running),
        .rollover (rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        run;
        logic        roll;
    } exp_t;

    typedef struct {
        logic        st;
        logic        sp;
        logic        cl;
        int          idle;
        logic [15:0] bcd;
        logic        run;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: elapsed seconds rather than digits.
    int   m_secs;
    int   m_presc;
    logic m_run;
    logic m_roll;

    function automatic logic [15:0] to_bcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_presc = 0;
        m_run   = 1'b0;
        m_roll  = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic cl);
        logic tk;
        tk = m_run && (m_presc == int'(TickDiv) - 1);
        m_roll = 1'b0;
        if (cl) begin
            m_secs  = 0;
            m_presc = 0;
        end else begin
            if (m_run) m_presc = tk ? 0 : m_presc + 1;
            if (tk) begin
                m_roll = (m_secs == 3599);
                m_secs = (m_secs + 1) % 3600;
            end
        end
        m_run = m_run ? !sp : (st && !sp);
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic st, input logic sp, input logic cl);
        exp_t e;
        @(negedge clk);
        start = st;
        stop  = sp;
        clear = cl;
        model_step(st, sp, cl);
        e.bcd  = to_bcd(m_secs);
        e.run  = m_run;
        e.roll = m_roll;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got no entry expected one at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("sb", {dut_bcd, running, rollover}, {e.bcd, e.run, e.roll});
        end
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    vec_t vecs[11];

    initial begin
        // Continues from 00:10, RUNNING, prescaler 0.
        vecs[0]  = '{st: 0, sp: 1, cl: 0, idle: 10, bcd: 16'h0010, run: 0};
        vecs[1]  = '{st: 1, sp: 0, cl: 0, idle: 2,  bcd: 16'h0010, run: 1};
        vecs[2]  = '{st: 0, sp: 0, cl: 0, idle: 0,  bcd: 16'h0011, run: 1};
        vecs[3]  = '{st: 1, sp: 1, cl: 0, idle: 0,  bcd: 16'h0011, run: 0};
        vecs[4]  = '{st: 1, sp: 1, cl: 0, idle: 3,  bcd: 16'h0011, run: 0};
        vecs[5]  = '{st: 0, sp: 0, cl: 1, idle: 0,  bcd: 16'h0000, run: 0};
        vecs[6]  = '{st: 1, sp: 0, cl: 1, idle: 0,  bcd: 16'h0000, run: 1};
        vecs[7]  = '{st: 0, sp: 0, cl: 0, idle: 26, bcd: 16'h0006, run: 1};
        vecs[8]  = '{st: 0, sp: 0, cl: 0, idle: 3,  bcd: 16'h0007, run: 1};
        vecs[9]  = '{st: 0, sp: 0, cl: 1, idle: 0,  bcd: 16'h0000, run: 1};
        vecs[10] = '{st: 0, sp: 1, cl: 1, idle: 0,  bcd: 16'h0000, run: 0};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", {dut_bcd, running, rollover}, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First tick lands exactly TickDiv cycles after the start edge.
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) check("pre_tick", {2'b0, dut_bcd}, 18'h0);
        idle(3);
        check("pre_tick3", {2'b0, dut_bcd}, 18'h0);
        idle(1);
        check("first_tick", {2'b0, dut_bcd}, 18'h0001);
        idle(36);
        check("run40", {dut_bcd, running, rollover}, {16'h0010, 1'b1, 1'b0});

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].st, vecs[i].sp, vecs[i].cl);
            idle(vecs[i].idle);
            check($sformatf("vec%0d", i), {dut_bcd, running, rollover},
                  {vecs[i].bcd, vecs[i].run, 1'b0});
        end

        // Pause after two counted cycles; restart resumes the partial second.
        cycle(1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("paused", {dut_bcd, running, rollover}, 18'h0);
        end
        cycle(1'b1, 1'b0, 1'b0);
        idle(1);
        check("resume_hold", {dut_bcd, running, rollover}, {16'h0000, 1'b1, 1'b0});
        idle(1);
        check("resume_tick", {2'b0, dut_bcd}, 18'h0001);

        idle(232);
        check("at_0059", {2'b0, dut_bcd}, 18'h0059);
        idle(3);
        check("hold_0059", {2'b0, dut_bcd}, 18'h0059);
        idle(1);
        check("carry_0100", {2'b0, dut_bcd}, 18'h0100);

        idle(14156);
        check("at_5959", {dut_bcd, running, rollover}, {16'h5959, 1'b1, 1'b0});
        idle(3);
        check("hold_5959", {dut_bcd, running, rollover}, {16'h5959, 1'b1, 1'b0});
        idle(1);
        check("wrap", {dut_bcd, running, rollover}, {16'h0000, 1'b1, 1'b1});
        idle(1);
        check("wrap_pulse_end", {17'h0, rollover}, 18'h0);
        idle(3);
        check("after_wrap", {dut_bcd, running, rollover}, {16'h0001, 1'b1, 1'b0});

        idle(3012);
        check("at_1234", {dut_bcd, running}, {1'b0, 16'h1234, 1'b1});
        idle(2);

        // Asynchronous reset mid-cycle, released before the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {dut_bcd, running, rollover}, 18'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check("post_reset_idle", {dut_bcd, running, rollover}, 18'h0);
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);
        check("post_reset_run", {dut_bcd, running, rollover}, {16'h0001, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clock cycles per one-second count tick (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, single-cycle pulse; requests counting.
REQ-005 The block SHALL have port stop, input, 1, single-cycle pulse; requests pause.
REQ-006 The block SHALL have port clear, input, 1, single-cycle pulse; zeroes the time.
REQ-007 The block SHALL have port sec_ones, output, 4, BCD seconds units, 0-9.
REQ-008 The block SHALL have port sec_tens, output, 4, BCD seconds tens, 0-5.
REQ-009 The block SHALL have port min_ones, output, 4, BCD minutes units, 0-9.
REQ-010 The block SHALL have port min_tens, output, 4, BCD minutes tens, 0-5.
REQ-011 The block SHALL have port running, output, 1, high while in RUNNING state.
REQ-012 The block SHALL have port rollover, output, 1, one-cycle pulse on the 59:59 -> 00:00 wrap.
REQ-013 Each digit output SHALL directly drive one 4-bit BCD input of a downstream seven-segment decoder; no value above 9 SHALL ever appear on any digit output.

Function
REQ-014 Control SHALL be a two-state machine: STOPPED, RUNNING.
REQ-015 STOPPED -> RUNNING on start=1 and stop=0; RUNNING -> STOPPED on stop=1; start and stop together SHALL leave or put the block in STOPPED (stop wins).
REQ-016 start while RUNNING and stop while STOPPED SHALL have no effect.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only while RUNNING, hold while STOPPED, and wrap to 0 after TICK_DIV-1.
REQ-018 A count tick SHALL occur in the cycle the prescaler equals TICK_DIV-1 while RUNNING; digit outputs SHALL show the incremented time from the next cycle (registered, 1-cycle latency).
REQ-019 First tick after start from a cleared prescaler SHALL occur exactly TICK_DIV cycles after the start edge.
REQ-020 On tick: sec_ones increments; 9 -> 0 with carry to sec_tens; sec_tens 5 -> 0 with carry to min_ones; min_ones 9 -> 0 with carry to min_tens; min_tens 5 -> 0.
REQ-021 Wrap from 59:59 to 00:00 SHALL assert rollover for exactly the one cycle in which 00:00 first appears; counting SHALL continue.
REQ-022 clear SHALL zero all four digits and the prescaler on the next edge, SHALL NOT change state (RUNNING stays RUNNING), and SHALL override a coincident tick.
REQ-023 clear coincident with start or stop SHALL apply both: digits zeroed and state per REQ-015.
REQ-024 running SHALL be a registered output equal to (state == RUNNING).
REQ-025 Stop then start SHALL resume from the held prescaler value (no lost or extra partial second).

Reset
REQ-026 rst_n low SHALL immediately set state STOPPED, prescaler 0, all digits 0, running 0, rollover 0, independent of clk.
REQ-027 Reset asserted mid-count SHALL discard any pending tick; after release the block SHALL remain STOPPED until a start pulse.

Structure
REQ-028 A shared package bcd_pkg SHALL hold the state enum (STOPPED, RUNNING), BCD digit width 4, and constants DIGIT_MAX_UNITS=9, DIGIT_MAX_TENS=5.
REQ-029 One sub-module bcd_digit SHALL implement a single mod-(MAX+1) BCD digit with parameter MAX, inputs clk, rst_n, clr, inc, outputs digit[3:0] and carry (inc and digit==MAX); bcd_stopwatch SHALL instantiate it four times in a carry chain.
REQ-030 Prescaler width SHALL be $clog2(TICK_DIV) bits.

Verification (TICK_DIV=4)
REQ-031 Reset, then start pulse, run 40 cycles -> time 00:10, running=1, first sec_ones change exactly 4 cycles after start.
REQ-032 Preload via running to 00:59, one more tick -> 01:00, sec_tens 5 -> 0, min_ones 0 -> 1 in the same cycle.
REQ-033 Run to 59:59, one more tick -> 00:00 with rollover=1 for one cycle, counting continues to 00:01.
REQ-034 Start, 2 cycles, stop, wait 10 cycles, start -> next tick 2 cycles after restart; digits unchanged while stopped.
REQ-035 start and stop in the same cycle while STOPPED -> stays STOPPED; clear asserted on a tick cycle at 00:07 -> 00:00, running unchanged.
REQ-036 rst_n pulsed low mid-cycle at 12:34 while RUNNING -> outputs 00:00, running=0 before the next clk edge; no counting until start.
